// File: rtl/i2c_slave_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level constants.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_RX_DATA,
    ST_ACK_RX,
    ST_TX_DATA,
    ST_ACK_TX,
    ST_WAIT_STOP
  } state_e;

  localparam logic       I2C_ACK       = 1'b0;
  localparam logic       I2C_NACK      = 1'b1;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;
  localparam logic [3:0] LAST_BIT_IDX  = 4'd7;

endpackage

// File: rtl/i2c_slave_line_sync.sv
// SCL/SDA synchronizers with edge, START and STOP detection on the synced lines.
module i2c_slave_line_sync #(
  parameter int P_SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [P_SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                     scl_hist_q, sda_hist_q;
  logic                     scl_s, sda_s;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[P_SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[P_SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[P_SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[P_SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_hist_q;
  assign scl_fall_o = ~scl_s & scl_hist_q;
  assign start_o    = scl_s & sda_hist_q & ~sda_s;
  assign stop_o     = scl_s & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, byte receive/transmit, open-drain SDA, no clock stretching.
//  state        | meaning
//  ST_IDLE      | bus free, waiting for START
//  ST_ADDR      | shifting in address + R/W
//  ST_ACK_ADDR  | driving address ACK
//  ST_RX_DATA   | shifting in a write byte
//  ST_ACK_RX    | driving data ACK
//  ST_TX_DATA   | driving a read byte
//  ST_ACK_TX    | waiting for master ACK/NACK
//  ST_WAIT_STOP | not addressed, ignore bus until STOP/Sr
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] P_ADDR        = 7'h42,
  parameter int         P_SYNC_STAGES = 2
) (
  input  logic       iw_clk,
  input  logic       iw_reset,
  input  logic       iw_i2c_scl,
  inout  wire        io_i2c_sda,
  input  logic [7:0] iw_tx_data,
  output logic       ow_tx_req,
  output logic [7:0] ow_rx_data,
  output logic       ow_rx_valid,
  output logic       ow_nack,
  output logic       ow_busy
);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d, nack_q, nack_d, busy_q, busy_d;
  logic       sda_s, scl_rise, scl_fall, start, stop, addr_hit;

  i2c_slave_line_sync #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_line_sync (
    .clk_i     (iw_clk),
    .reset_i   (iw_reset),
    .scl_i     (iw_i2c_scl),
    .sda_i     (io_i2c_sda),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  assign addr_hit = (shift_q[7:1] == P_ADDR);

  always_ff @(posedge iw_clk) begin
    if (iw_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      nack_q     <= nack_d;
      busy_q     <= busy_d;
    end
  end

  // Bus conditions take priority over any scl_fall in the same cycle.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_ADDR;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR:     if (scl_fall && cnt_q == BITS_PER_BYTE)
                       state_d = addr_hit ? ST_ACK_ADDR : ST_WAIT_STOP;
        ST_ACK_ADDR: if (scl_fall) state_d = shift_q[0] ? ST_TX_DATA : ST_RX_DATA;
        ST_RX_DATA:  if (scl_fall && cnt_q == BITS_PER_BYTE) state_d = ST_ACK_RX;
        ST_ACK_RX:   if (scl_fall) state_d = ST_RX_DATA;
        ST_TX_DATA:  if (scl_fall && cnt_q == BITS_PER_BYTE) state_d = ST_ACK_TX;
        ST_ACK_TX:   if (scl_rise && sda_s == I2C_NACK) state_d = ST_WAIT_STOP;
                     else if (scl_fall) state_d = ST_TX_DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    nack_d     = 1'b0;
    if (start || stop) begin
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
            cnt_d    = 4'd0;
            sda_oe_d = addr_hit;
            busy_d   = addr_hit;
          end
        end
        ST_ACK_ADDR: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (shift_q[0]) begin
              tx_req_d = 1'b1;
              shift_d  = iw_tx_data;
              sda_oe_d = ~iw_tx_data[7];
            end
          end
        end
        ST_RX_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == LAST_BIT_IDX) begin
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b1;
          end
        end
        ST_ACK_RX: if (scl_fall) sda_oe_d = 1'b0;
        ST_TX_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == BITS_PER_BYTE) begin
              cnt_d    = 4'd0;
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_ACK_TX: begin
          if (scl_rise && sda_s == I2C_NACK) begin
            nack_d = 1'b1;
            busy_d = 1'b0;
          end else if (scl_fall) begin
            tx_req_d = 1'b1;
            shift_d  = iw_tx_data;
            sda_oe_d = ~iw_tx_data[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign io_i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
  assign ow_tx_req   = tx_req_q;
  assign ow_rx_data  = rx_data_q;
  assign ow_rx_valid = rx_valid_q;
  assign ow_nack     = nack_q;
  assign ow_busy     = busy_q;

endmodule
